// File: rtl/udp_rx_framer.sv
// udp_rx_framer: decodes UDP payload into packed I/Q sample words or indexed coefficient writes
module udp_rx_framer #(
  parameter int COEF_NUM = 16,
  parameter logic [7:0] CMD_IQ = 8'hAA,
  parameter logic [7:0] CMD_COEF = 8'hFF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  input  logic                        i_rx_last,
  output logic                        o_rx_ready,
  output logic [15:0]                 o_iq_data,
  output logic                        o_iq_valid,
  output logic                        o_iq_last,
  input  logic                        i_iq_ready,
  output logic                        o_coef_we,
  output logic [$clog2(COEF_NUM)-1:0] o_coef_addr,
  output logic [15:0]                 o_coef_data,
  output logic                        o_coef_done,
  output logic                        o_busy,
  output logic [7:0]                  o_err_cnt
);
  localparam int AW = $clog2(COEF_NUM);
  localparam logic [AW:0] FULL = (AW+1)'(COEF_NUM);
  typedef enum logic [2:0] {S_CMD, S_IQ_HI, S_IQ_LO, S_COEF_HI, S_COEF_LO, S_DRAIN} state_t;
  state_t state, state_nxt;
  logic [7:0] hi;
  logic [AW:0] idx;
  logic ovf, acc, err, full, coef_st;
  assign o_rx_ready = i_rst_n && !(state == S_IQ_LO && o_iq_valid && !i_iq_ready);
  assign acc = i_rx_valid && o_rx_ready;
  assign o_busy = state != S_CMD;
  assign full = idx == FULL;
  assign coef_st = state == S_COEF_HI || state == S_COEF_LO;
  always_comb begin
    state_nxt = state;
    err = 1'b0;
    if (acc)
      case (state)
        S_CMD: begin
          state_nxt = i_rx_last ? S_CMD : i_rx_data == CMD_IQ ? S_IQ_HI :
                      i_rx_data == CMD_COEF ? S_COEF_HI : S_DRAIN;
          err = !i_rx_last && i_rx_data != CMD_IQ && i_rx_data != CMD_COEF;
        end
        S_IQ_HI: begin
          state_nxt = i_rx_last ? S_CMD : S_IQ_LO;
          err = i_rx_last;
        end
        S_IQ_LO: state_nxt = i_rx_last ? S_CMD : S_IQ_HI;
        S_COEF_HI: begin
          state_nxt = i_rx_last ? S_CMD : S_COEF_LO;
          err = i_rx_last;
        end
        S_COEF_LO: begin
          state_nxt = i_rx_last ? S_CMD : S_COEF_HI;
          err = i_rx_last && (ovf || full);
        end
        S_DRAIN: state_nxt = i_rx_last ? S_CMD : S_DRAIN;
        default: state_nxt = S_CMD;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_CMD;
      hi <= '0;
      idx <= '0;
      ovf <= 1'b0;
      o_iq_data <= '0;
      o_iq_valid <= 1'b0;
      o_iq_last <= 1'b0;
      o_coef_we <= 1'b0;
      o_coef_addr <= '0;
      o_coef_data <= '0;
      o_coef_done <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state <= state_nxt;
      o_coef_we <= 1'b0;
      o_coef_done <= acc && i_rx_last && (coef_st || (state == S_CMD && i_rx_data == CMD_COEF));
      if (o_iq_valid && i_iq_ready) o_iq_valid <= 1'b0;
      if (err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      if (acc) begin
        if (state == S_CMD) begin
          idx <= '0;
          ovf <= 1'b0;
        end
        if (state == S_IQ_HI || state == S_COEF_HI) hi <= i_rx_data;
        if (state == S_IQ_LO) begin
          o_iq_data <= {hi, i_rx_data};
          o_iq_valid <= 1'b1;
          o_iq_last <= i_rx_last;
        end
        if (state == S_COEF_LO) begin
          if (full) ovf <= 1'b1;
          else begin
            o_coef_we <= 1'b1;
            o_coef_addr <= idx[AW-1:0];
            o_coef_data <= {hi, i_rx_data};
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end
endmodule
